// File: rtl/pov_column_sequencer_if.sv
// Column-timer / LED-stage handshake bundle for pov_column_sequencer.
// The master drives the timing and control inputs. The slave (the sequencer) drives the load and status outputs.
interface pov_column_sequencer_if #(
  parameter int COL_W = 8
);
  logic             run;
  logic             start;
  logic [1:0]       mode;
  logic             new_col;
  logic             index;
  logic             load_led;
  logic [COL_W-1:0] col_addr;
  logic             invert;
  logic             frame_done;
  logic             busy;
  logic             overrun;

  modport master (
    output run, start, mode, new_col, index,
    input  load_led, col_addr, invert, frame_done, busy, overrun
  );

  modport slave (
    input  run, start, mode, new_col, index,
    output load_led, col_addr, invert, frame_done, busy, overrun
  );
endinterface

// File: rtl/pov_column_sequencer.sv
// Sequences column loads for a rotating POV LED bar.
// It counts columns and revolutions and applies a scroll offset and/or invert effect per step.
module pov_column_sequencer #(
  parameter int NUM_COLS      = 256,
  parameter int COL_W         = 8,
  parameter int REVS_PER_STEP = 4,
  parameter int REV_W         = 4,
  parameter int STEP          = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  pov_column_sequencer_if.slave bus
);
  // One extra bit lets the column count reach NUM_COLS and lets sums be wrapped without a divider.
  localparam int SUM_W = COL_W + 1;
  localparam logic [SUM_W-1:0] NUM_COLS_S = SUM_W'(NUM_COLS);
  localparam logic [SUM_W-1:0] STEP_S     = SUM_W'(STEP);
  localparam logic [REV_W-1:0] REV_LAST   = REV_W'(REVS_PER_STEP - 1);

  typedef enum logic [1:0] {
    MODE_FIXED      = 2'd0,
    MODE_SCROLL     = 2'd1,
    MODE_BLINK      = 2'd2,
    MODE_SCROLL_INV = 2'd3
  } mode_t;

  typedef enum logic [2:0] {
    IDLE, ARM, WAIT_COL, LOAD, REV_END, SHIFT
  } state_t;

  state_t           state_q, state_d;
  mode_t            mode_q, mode_d;
  logic [SUM_W-1:0] col_cnt_q, col_cnt_d;
  logic [REV_W-1:0] rev_cnt_q, rev_cnt_d;
  logic [COL_W-1:0] offset_q, offset_d;
  logic             idx_pend_q, idx_pend_d;
  logic             load_led_q, load_led_d;
  logic [COL_W-1:0] col_addr_q, col_addr_d;
  logic             invert_q, invert_d;
  logic             frame_done_q, frame_done_d;
  logic             busy_q, busy_d;
  logic             overrun_q, overrun_d;

  logic [SUM_W-1:0] col_sum, off_sum;
  logic [COL_W-1:0] col_wrap, off_wrap;
  logic             scroll_en, blink_en;

  assign col_sum  = {1'b0, col_cnt_q[COL_W-1:0]} + {1'b0, offset_q};
  assign col_wrap = COL_W'((col_sum >= NUM_COLS_S) ? col_sum - NUM_COLS_S : col_sum);
  assign off_sum  = {1'b0, offset_q} + STEP_S;
  assign off_wrap = COL_W'((off_sum >= NUM_COLS_S) ? off_sum - NUM_COLS_S : off_sum);

  assign scroll_en = (mode_q == MODE_SCROLL) || (mode_q == MODE_SCROLL_INV);
  assign blink_en  = (mode_q == MODE_BLINK)  || (mode_q == MODE_SCROLL_INV);

  // Outputs are registered. The values seen in LOAD and REV_END are computed on the transition into those states.
  always_comb begin
    // NOTE: every signal gets its hold value first, so no branch can leave it unassigned and infer a latch.
    state_d      = state_q;
    mode_d       = mode_q;
    col_cnt_d    = col_cnt_q;
    rev_cnt_d    = rev_cnt_q;
    offset_d     = offset_q;
    idx_pend_d   = idx_pend_q;
    col_addr_d   = col_addr_q;
    invert_d     = invert_q;
    overrun_d    = overrun_q;
    load_led_d   = 1'b0;
    frame_done_d = 1'b0;

    if (state_q != IDLE && !bus.run) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.run && bus.start) begin
            mode_d  = mode_t'(bus.mode);
            state_d = ARM;
          end
        end
        ARM: begin
          col_cnt_d  = '0;
          rev_cnt_d  = '0;
          offset_d   = '0;
          invert_d   = 1'b0;
          overrun_d  = 1'b0;
          idx_pend_d = 1'b0;
          state_d    = WAIT_COL;
        end
        WAIT_COL: begin
          if (bus.new_col) begin
            state_d = LOAD;
            if (bus.index) idx_pend_d = 1'b1;
            if (col_cnt_q < NUM_COLS_S) begin
              load_led_d = 1'b1;
              col_cnt_d  = col_cnt_q + SUM_W'(1);
              col_addr_d = scroll_en ? col_wrap : col_cnt_q[COL_W-1:0];
            end else begin
              overrun_d = 1'b1;
            end
          end else if (bus.index) begin
            state_d      = REV_END;
            frame_done_d = 1'b1;
            col_cnt_d    = '0;
            idx_pend_d   = 1'b0;
          end
        end
        LOAD: begin
          if (idx_pend_q || bus.index) begin
            state_d      = REV_END;
            frame_done_d = 1'b1;
            col_cnt_d    = '0;
            idx_pend_d   = 1'b0;
          end else begin
            state_d = WAIT_COL;
          end
        end
        REV_END: begin
          if (rev_cnt_q == REV_LAST) begin
            state_d = SHIFT;
          end else begin
            rev_cnt_d = rev_cnt_q + REV_W'(1);
            state_d   = WAIT_COL;
          end
        end
        SHIFT: begin
          rev_cnt_d = '0;
          if (scroll_en) offset_d = off_wrap;
          if (blink_en)  invert_d = ~invert_q;
          state_d = WAIT_COL;
        end
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      mode_q       <= MODE_FIXED;
      col_cnt_q    <= '0;
      rev_cnt_q    <= '0;
      offset_q     <= '0;
      idx_pend_q   <= 1'b0;
      load_led_q   <= 1'b0;
      col_addr_q   <= '0;
      invert_q     <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking updates let every flop sample the pre-edge values, whatever the statement order.
      state_q      <= state_d;
      mode_q       <= mode_d;
      col_cnt_q    <= col_cnt_d;
      rev_cnt_q    <= rev_cnt_d;
      offset_q     <= offset_d;
      idx_pend_q   <= idx_pend_d;
      load_led_q   <= load_led_d;
      col_addr_q   <= col_addr_d;
      invert_q     <= invert_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
      overrun_q    <= overrun_d;
    end
  end

  assign bus.load_led   = load_led_q;
  assign bus.col_addr   = col_addr_q;
  assign bus.invert     = invert_q;
  assign bus.frame_done = frame_done_q;
  assign bus.busy       = busy_q;
  assign bus.overrun    = overrun_q;
endmodule
